spi_ram: RTL

- Command-driven single-port synchronous RAM directly downstream of the SPI slave.
- Consumes the slave's 10-bit parallel word `din` and its `rx_valid` strobe.
- Returns read data on `dout`, qualified by `tx_valid`, which the slave serialises onto MISO.
- `din[9:8]` is the command code; `din[7:0]` is the address or data payload.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_ram_mem.sv | 31 +++
 rtl/spi_ram.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word layout and command codes
// used by the SPI slave, the command RAM and the wrapper.
package spi_pkg;

  localparam int WORD_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Plain single-port synchronous RAM with a registered read port.
// Write and read share one address; the caller never asserts both.
module spi_ram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command-driven RAM behind the SPI slave: edge-detects rx_valid,
// decodes din[9:8], and returns read data on dout with tx_valid.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

  logic                 rx_valid_q, rx_valid_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 rd_pend_q, rd_pend_d;

  logic                 accept;
  cmd_e                 cmd;
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_rdata;

  assign accept = rx_valid & ~rx_valid_q;
  assign cmd    = cmd_e'(din[9:8]);

  // Next-state: command decode on the rx_valid rising edge,
  // plus completion of a read issued on the previous cycle.
  always_comb begin
    rx_valid_d = rx_valid;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    rd_pend_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = wr_addr_q;

    if (rd_pend_q) begin
      dout_d     = mem_rdata;
      tx_valid_d = 1'b1;
    end

    if (accept) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        CMD_WR_DATA: begin
          mem_we     = 1'b1;
          mem_addr   = wr_addr_q;
          tx_valid_d = 1'b0;
          if (AUTO_INC != 0) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        CMD_RD_DATA: begin
          mem_re    = 1'b1;
          mem_addr  = rd_addr_q;
          rd_pend_d = 1'b1;
          if (AUTO_INC != 0) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
          end
        end
        default: begin
        end
      endcase
    end

    // A command landing on a reset edge must not touch memory.
    if (!rst_n) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  spi_ram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE),
    .DW    (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (din[DATA_W-1:0]),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule
